// File: rtl/cache_drain_unit.sv
// Cache drain engine: waits for the store buffer to empty, then writes every valid dirty line back to memory.
// Optional macro DRAIN_STATS_EN adds a saturating per-drain write counter output (drain_wr_count).
module cache_drain_unit #(
  parameter int NUM_LINES = 4,
  parameter int LINE_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ADDR_W - IDX_W - 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              drain_req,
  output logic              drain_busy,
  output logic              drain_done,
  input  logic              sb_empty,
  output logic              cl_rd_en,
  output logic [IDX_W-1:0]  cl_idx,
  input  logic              cl_valid,
  input  logic              cl_dirty,
  input  logic [TAG_W-1:0]  cl_tag,
  input  logic [LINE_W-1:0] cl_data,
  output logic              cl_clean_en,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack
`ifdef DRAIN_STATS_EN
  ,
  output logic [15:0]       drain_wr_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SB,
    READ,
    CHECK,
    WRITE,
    NEXT,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;

  // Handshake outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      drain_busy  <= 1'b0;
      drain_done  <= 1'b0;
      cl_rd_en    <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
`ifdef DRAIN_STATS_EN
      drain_wr_count <= '0;
`endif
    end else begin
      drain_done <= 1'b0;
      cl_rd_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_req) begin
            state      <= WAIT_SB;
            ptr        <= '0;
            drain_busy <= 1'b1;
`ifdef DRAIN_STATS_EN
            drain_wr_count <= '0;
`endif
          end
        end
        WAIT_SB: begin
          if (sb_empty) begin
            state    <= READ;
            cl_rd_en <= 1'b1;
          end
        end
        READ: state <= CHECK;
        CHECK: begin
          mem_wr_addr <= {cl_tag, ptr, 4'b0000};
          mem_wr_data <= cl_data;
          if (cl_valid && cl_dirty) begin
            state      <= WRITE;
            mem_wr_req <= 1'b1;
          end else begin
            state <= NEXT;
          end
        end
        WRITE: begin
          if (mem_wr_ack) begin
            state      <= NEXT;
            mem_wr_req <= 1'b0;
`ifdef DRAIN_STATS_EN
            if (drain_wr_count != 16'hFFFF) drain_wr_count <= drain_wr_count + 16'd1;
`endif
          end
        end
        NEXT: begin
          if (ptr == IDX_W'(NUM_LINES - 1)) begin
            state      <= DONE;
            drain_busy <= 1'b0;
            drain_done <= 1'b1;
          end else begin
            state    <= READ;
            ptr      <= ptr + 1'b1;
            cl_rd_en <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ptr   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The clean strobe must coincide with the ack cycle, which can be the very first WRITE cycle.
  assign cl_clean_en = (state == WRITE) && mem_wr_ack;
  assign cl_idx      = ptr;

endmodule
